// File: rtl/axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_slave
//   AXI4-Lite responder holding NUM_REGS 32-bit memory-mapped registers.
//   The last register index is a read-only ID register returning ID_VALUE.
//   Write and read paths are independent. AW and W may arrive in either
//   order or together. Out-of-range accesses, and writes to the ID register,
//   complete with SLVERR.
//
// Ports
//   ACLK, ARESET             clock (rising edge), async active-high reset
//   AW*  (VALID/READY/ADDR)  write address channel
//   W*   (VALID/READY/DATA/STRB) write data channel
//   B*   (VALID/READY/RESP)  write response channel
//   AR*  (VALID/READY/ADDR)  read address channel
//   R*   (VALID/READY/DATA/RESP) read data channel
//   reg_out                  flattened register contents, reg i at
//                            [32i+31:32i]; the ID slot carries ID_VALUE
// ---------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int          Width    = 32,
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'hA0A1_0001
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [Width-1:0]         AWADDR,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [Width-1:0]         WDATA,
    input  logic [Width/8-1:0]       WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [Width-1:0]         ARADDR,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [Width-1:0]         RDATA,
    output logic [1:0]               RRESP,
    output logic [NUM_REGS*32-1:0]   reg_out
);

    localparam int               IDX_W       = $clog2(NUM_REGS);
    localparam int               LANES       = Width / 8;
    localparam logic [IDX_W-1:0] ID_IDX      = IDX_W'(NUM_REGS - 1);
    localparam logic [Width-1:0] ADDR_LIMIT  = Width'(NUM_REGS * 4);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Write-path state
    logic                 aw_held_r;
    logic                 w_held_r;
    logic [Width-1:0]     aw_addr_r;
    logic [Width-1:0]     w_data_r;
    logic [LANES-1:0]     w_strb_r;
    logic                 bvalid_r;
    logic [1:0]           bresp_r;

    // Read-path state
    logic                 rvalid_r;
    logic [Width-1:0]     rdata_r;
    logic [1:0]           rresp_r;

    // Writable registers only; the ID slot is a constant
    logic [31:0]          regs_r [NUM_REGS-1];

    // Combinational helpers
    logic                 aw_hs_s;
    logic                 w_hs_s;
    logic                 ar_hs_s;
    logic                 commit_s;
    logic [Width-1:0]     wr_addr_s;
    logic [Width-1:0]     wr_data_s;
    logic [LANES-1:0]     wr_strb_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic                 wr_ok_s;
    logic [IDX_W-1:0]     rd_idx_s;
    logic                 rd_in_range_s;
    logic [Width-1:0]     rd_val_s;

    // Ready signals depend only on registered state; reset forces them low
    assign AWREADY = !ARESET && !aw_held_r && !bvalid_r;
    assign WREADY  = !ARESET && !w_held_r  && !bvalid_r;
    assign ARREADY = !ARESET && !rvalid_r;

    assign BVALID  = bvalid_r;
    assign BRESP   = bresp_r;
    assign RVALID  = rvalid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;

    assign aw_hs_s = AWVALID && AWREADY;
    assign w_hs_s  = WVALID  && WREADY;
    assign ar_hs_s = ARVALID && ARREADY;

    // Commit when address and data are both available this edge; a channel
    // handshaking now supplies its value directly instead of the held copy
    always_comb begin
        commit_s  = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
        if (aw_held_r) begin
            wr_addr_s = aw_addr_r;
        end else begin
            wr_addr_s = AWADDR;
        end
        if (w_held_r) begin
            wr_data_s = w_data_r;
            wr_strb_s = w_strb_r;
        end else begin
            wr_data_s = WDATA;
            wr_strb_s = WSTRB;
        end
        wr_idx_s = wr_addr_s[IDX_W+1:2];
        wr_ok_s  = (wr_addr_s < ADDR_LIMIT) && (wr_idx_s != ID_IDX);
    end

    // Read decode and data mux
    always_comb begin
        rd_idx_s      = ARADDR[IDX_W+1:2];
        rd_in_range_s = (ARADDR < ADDR_LIMIT);
        rd_val_s      = {Width{1'b0}};
        if (rd_in_range_s) begin
            if (rd_idx_s == ID_IDX) begin
                rd_val_s = ID_VALUE;
            end else begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (rd_idx_s == IDX_W'(i)) begin
                        rd_val_s = regs_r[i];
                    end else begin
                        rd_val_s = rd_val_s;
                    end
                end
            end
        end else begin
            rd_val_s = {Width{1'b0}};
        end
    end

    // Write channel capture, commit and response handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_addr_r <= {Width{1'b0}};
            w_data_r  <= {Width{1'b0}};
            w_strb_r  <= {LANES{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    aw_addr_r <= AWADDR;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    w_data_r <= WDATA;
                    w_strb_r <= WSTRB;
                end
                if (bvalid_r && BREADY) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

    // Register bank update with byte-lane enables
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (commit_s && wr_ok_s && (wr_idx_s == IDX_W'(i))) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (wr_strb_s[b]) begin
                            regs_r[i][8*b +: 8] <= wr_data_s[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read channel: one-cycle latency, data held until accepted
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {Width{1'b0}};
            rresp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_val_s;
            rresp_r  <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    // Export register contents; the ID slot is constant
    genvar g;
    generate
        for (g = 0; g < NUM_REGS - 1; g++) begin : g_reg_out
            assign reg_out[32*g +: 32] = regs_r[g];
        end
    endgenerate
    assign reg_out[32*(NUM_REGS-1) +: 32] = ID_VALUE;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//   Self-checking bench for axi_lite_reg_slave with a behavioural register
//   model. Directed scenarios followed by randomized reads and writes.
// ---------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int          NR    = 8;
    localparam logic [31:0] ID_V  = 32'hA0A1_0001;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [31:0]       AWADDR = 32'h0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [31:0]       WDATA = 32'h0;
    logic [3:0]        WSTRB = 4'h0;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [1:0]        BRESP;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [31:0]       ARADDR = 32'h0;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic [NR*32-1:0]  reg_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [NR];

    axi_lite_reg_slave #(.Width(32), .NUM_REGS(NR), .ID_VALUE(ID_V)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [NR*32-1:0] obs,
                             input logic [NR*32-1:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [NR*32-1:0] exp_reg_out();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[32*i +: 32] = (i == NR - 1) ? ID_V : model[i];
        end
        return v;
    endfunction

    // mode 0: AW and W together; 1: W first; 2: AW first. gap = idle edges
    // between the two handshakes, stall = cycles BREADY is held low.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int mode,
                            input int gap, input int stall);
        logic [1:0]  exp_resp;
        logic [31:0] mask;
        logic        writable;
        int          idx;
        writable = 1'b0;
        idx = 0;
        if (addr < NR * 4) begin
            idx = int'(addr / 4);
            writable = (idx != NR - 1);
        end
        exp_resp = writable ? 2'b00 : 2'b10;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        check_val("wr_awready_idle", AWREADY, 1);
        check_val("wr_wready_idle", WREADY, 1);
        if (mode == 0) begin
            AWVALID = 1'b1; AWADDR = addr;
            WVALID = 1'b1; WDATA = data; WSTRB = strb;
            step();
            AWVALID = 1'b0; WVALID = 1'b0;
        end else if (mode == 1) begin
            WVALID = 1'b1; WDATA = data; WSTRB = strb;
            step();
            WVALID = 1'b0; WDATA = $urandom; WSTRB = 4'h0;
            for (int i = 0; i < gap; i++) begin
                check_val("wr_wait_wready", WREADY, 0);
                check_val("wr_wait_bvalid", BVALID, 0);
                step();
            end
            check_val("wr_wait_wready", WREADY, 0);
            AWVALID = 1'b1; AWADDR = addr;
            step();
            AWVALID = 1'b0;
        end else begin
            AWVALID = 1'b1; AWADDR = addr;
            step();
            AWVALID = 1'b0; AWADDR = $urandom;
            for (int i = 0; i < gap; i++) begin
                check_val("wr_wait_awready", AWREADY, 0);
                check_val("wr_wait_bvalid", BVALID, 0);
                step();
            end
            WVALID = 1'b1; WDATA = data; WSTRB = strb;
            step();
            WVALID = 1'b0;
        end
        if (writable) begin
            model[idx] = (model[idx] & ~mask) | (data & mask);
        end
        check_val("wr_bvalid", BVALID, 1);
        check_val("wr_bresp", BRESP, exp_resp);
        check_val("wr_reg_out", reg_out, exp_reg_out());
        for (int i = 0; i < stall; i++) begin
            check_val("wr_stall_awready", AWREADY, 0);
            check_val("wr_stall_wready", WREADY, 0);
            step();
            check_val("wr_stall_bvalid", BVALID, 1);
            check_val("wr_stall_bresp", BRESP, exp_resp);
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check_val("wr_bvalid_drop", BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        if (addr >= NR * 4) begin
            exp_data = 32'h0; exp_resp = 2'b10;
        end else if (int'(addr / 4) == NR - 1) begin
            exp_data = ID_V; exp_resp = 2'b00;
        end else begin
            exp_data = model[int'(addr / 4)]; exp_resp = 2'b00;
        end
        check_val("rd_arready_idle", ARREADY, 1);
        ARVALID = 1'b1; ARADDR = addr;
        step();
        ARVALID = 1'b0; ARADDR = $urandom;
        check_val("rd_rvalid", RVALID, 1);
        check_val("rd_rdata", RDATA, exp_data);
        check_val("rd_rresp", RRESP, exp_resp);
        for (int i = 0; i < stall; i++) begin
            check_val("rd_stall_arready", ARREADY, 0);
            step();
            check_val("rd_stall_rvalid", RVALID, 1);
            check_val("rd_stall_rdata", RDATA, exp_data);
            check_val("rd_stall_rresp", RRESP, exp_resp);
        end
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check_val("rd_rvalid_drop", RVALID, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) begin
            return 32'($urandom_range(0, NR - 2) * 4 + $urandom_range(0, 3));
        end else if (sel == 7) begin
            return 32'((NR - 1) * 4 + $urandom_range(0, 3));
        end else if (sel == 8) begin
            return 32'(NR * 4 + $urandom_range(0, 63));
        end else begin
            return {1'b1, 31'($urandom)};
        end
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) model[i] = 32'h0;

        // Reset then idle
        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_awready", AWREADY, 0);
        check_val("rst_arready", ARREADY, 0);
        ARESET = 1'b0;
        step();
        check_val("idle_awready", AWREADY, 1);
        check_val("idle_wready", WREADY, 1);
        check_val("idle_arready", ARREADY, 1);
        check_val("idle_bvalid", BVALID, 0);
        check_val("idle_rvalid", RVALID, 0);
        check_val("idle_reg_out", reg_out, exp_reg_out());
        check_val("idle_id_slot", reg_out[NR*32-1 -: 32], 32'hA0A1_0001);

        // AW and W together, then read back
        do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h04, 0);

        // W two cycles ahead of AW with partial strobes
        do_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'h08, 32'h1122_3344, 4'b0101, 1, 1, 0);
        check_val("strb_reg2", reg_out[95:64], 32'hFF22_FF44);

        // Response stalled 5 cycles with a concurrent read of reg 1
        fork
            do_write(32'h0C, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
            begin
                step(); step();
                do_read(32'h04, 1);
            end
        join

        // ID and out-of-range accesses
        do_write(32'h1C, 32'h5555_5555, 4'hF, 0, 0, 0);
        do_write(32'h40, 32'h6666_6666, 4'hF, 2, 1, 0);
        do_read(32'h40, 0);
        do_read(32'h1C, 0);
        do_write(32'h14, 32'h7777_7777, 4'h0, 0, 0, 0);

        // Same-edge read and write of one register returns the old value
        do_write(32'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
        fork
            do_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
            do_read(32'h10, 0);
        join
        do_read(32'h10, 0);

        // Reset mid-transaction
        AWVALID = 1'b1; AWADDR = 32'h04;
        step();
        AWVALID = 1'b0;
        check_val("held_awready", AWREADY, 0);
        ARVALID = 1'b1; ARADDR = 32'h08;
        step();
        ARVALID = 1'b0;
        check_val("held_rvalid", RVALID, 1);
        #2;
        ARESET = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        check_val("arst_awready", AWREADY, 0);
        check_val("arst_wready", WREADY, 0);
        check_val("arst_arready", ARREADY, 0);
        check_val("arst_bvalid", BVALID, 0);
        check_val("arst_rvalid", RVALID, 0);
        check_val("arst_rdata", RDATA, 0);
        check_val("arst_rresp", RRESP, 0);
        check_val("arst_bresp", BRESP, 0);
        check_val("arst_reg_out", reg_out, exp_reg_out());
        step();
        ARESET = 1'b0;
        step();
        check_val("rel_awready", AWREADY, 1);
        WVALID = 1'b1; WDATA = 32'h9999_9999; WSTRB = 4'hF;
        step();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("rel_no_commit_b", BVALID, 0);
            check_val("rel_no_commit_regs", reg_out, exp_reg_out());
            step();
        end
        AWVALID = 1'b1; AWADDR = 32'h18;
        step();
        AWVALID = 1'b0;
        model[6] = 32'h9999_9999;
        check_val("rel_commit_b", BVALID, 1);
        check_val("rel_commit_resp", BRESP, 2'b00);
        check_val("rel_commit_regs", reg_out, exp_reg_out());
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)));
            end else begin
                do_read(rand_addr(), int'($urandom_range(0, 3)));
            end
        end
        check_val("final_reg_out", reg_out, exp_reg_out());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
